// File: rtl/sha_pad_absorb.sv
// Packs a word stream into SHA-3 rate blocks with 0x06 .. 0x80 padding for a Keccak core.
// Define SHA_PAD_BYTE_SWAP_EN to byte-reverse every accepted word before it is placed.
module sha_pad_absorb #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [DATA_WIDTH-1:0] S_TDATA,
   input  logic                  S_TVALID,
   output logic                  S_TREADY,
   input  logic                  S_TLAST,
   input  logic [1:0]            S_TUSER,
   output logic [1599:0]         Block,
   output logic                  Block_valid,
   output logic                  Block_last,
   output logic [1:0]            Block_mode,
   input  logic                  Core_ready
);

   localparam int unsigned BLK_W  = 1600;
   localparam int unsigned NBYTE  = DATA_WIDTH / 8;
   localparam int unsigned DW_LOG = $clog2(DATA_WIDTH);
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned RATE_W = 11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_PADBLK = 2'd3
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [BLK_W-1:0]   block_q;
   logic               valid_q;
   logic               last_q;
   logic [1:0]         mode_q;
   logic               tready_q;
   logic               padpend_q;

   logic [1:0]            mode_d;
   logic [RATE_W-1:0]     rate_d;
   logic [CNT_W-1:0]      last_idx_d;
   logic [RATE_W-1:0]     word_lo_d;
   logic [RATE_W-1:0]     pad_lo_d;
   logic [RATE_W-1:0]     tail_lo_d;
   logic [DATA_WIDTH-1:0] word_d;
   logic                  accept_d;
   logic                  is_last_word_d;
   logic                  pad_here_d;
   logic [BLK_W-1:0]      fill_d;
   logic [BLK_W-1:0]      pblk_d;

   function automatic logic [RATE_W-1:0] rate_bits(input logic [1:0] m);
      case (m)
         2'd0:    return RATE_W'(1152);
         2'd1:    return RATE_W'(1088);
         2'd2:    return RATE_W'(832);
         default: return RATE_W'(576);
      endcase
   endfunction

   // The mode of a message's first word applies immediately; later words use the latched mode.
   always_comb begin
      mode_d         = (state_q == ST_IDLE) ? S_TUSER : mode_q;
      rate_d         = rate_bits(mode_d);
      last_idx_d     = CNT_W'(rate_d >> DW_LOG) - CNT_W'(1);
      word_lo_d      = RATE_W'(cnt_q) * RATE_W'(DATA_WIDTH);
      pad_lo_d       = word_lo_d + RATE_W'(DATA_WIDTH);
      tail_lo_d      = rate_d - RATE_W'(8);
      accept_d       = tready_q & S_TVALID;
      is_last_word_d = (cnt_q == last_idx_d);
      pad_here_d     = S_TLAST & ~is_last_word_d;
   end

   always_comb begin
      word_d = S_TDATA;
`ifdef SHA_PAD_BYTE_SWAP_EN
      for (int b = 0; b < NBYTE; b++) begin
         word_d[8*b +: 8] = S_TDATA[8*(NBYTE-1-b) +: 8];
      end
`endif
   end

   // Block image after the current word, including in-block padding on a short final word.
   always_comb begin
      fill_d = block_q;
      fill_d[word_lo_d +: DATA_WIDTH] = word_d;
      if (pad_here_d) begin
         fill_d[pad_lo_d +: 8]  = fill_d[pad_lo_d +: 8] | 8'h06;
         fill_d[tail_lo_d +: 8] = fill_d[tail_lo_d +: 8] | 8'h80;
      end
   end

   always_comb begin
      pblk_d                  = '0;
      pblk_d[7:0]             = 8'h06;
      pblk_d[tail_lo_d +: 8]  = pblk_d[tail_lo_d +: 8] | 8'h80;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         block_q   <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         mode_q    <= 2'd0;
         tready_q  <= 1'b0;
         padpend_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_FILL: begin
               tready_q <= 1'b1;
               if (accept_d) begin
                  block_q <= fill_d;
                  if (state_q == ST_IDLE) begin
                     mode_q <= S_TUSER;
                  end
                  if (S_TLAST || is_last_word_d) begin
                     state_q   <= ST_HOLD;
                     tready_q  <= 1'b0;
                     valid_q   <= 1'b1;
                     last_q    <= pad_here_d;
                     padpend_q <= S_TLAST & is_last_word_d;
                  end else begin
                     state_q <= ST_FILL;
                     cnt_q   <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (valid_q && Core_ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  block_q <= '0;
                  cnt_q   <= '0;
                  if (padpend_q) begin
                     state_q   <= ST_PADBLK;
                     padpend_q <= 1'b0;
                  end else if (last_q) begin
                     state_q  <= ST_IDLE;
                     tready_q <= 1'b1;
                  end else begin
                     state_q  <= ST_FILL;
                     tready_q <= 1'b1;
                  end
               end
            end
            ST_PADBLK: begin
               block_q <= pblk_d;
               valid_q <= 1'b1;
               last_q  <= 1'b1;
               state_q <= ST_HOLD;
            end
            default: begin
               state_q  <= ST_IDLE;
               tready_q <= 1'b0;
            end
         endcase
      end
   end

   assign S_TREADY    = tready_q;
   assign Block       = block_q;
   assign Block_valid = valid_q;
   assign Block_last  = last_q;
   assign Block_mode  = mode_q;

endmodule

// File: tb/tb_sha_pad_absorb.sv
// Randomized bench for sha_pad_absorb (64-bit words) against a byte-level SHA-3 padding model.
module tb_sha_pad_absorb;

   localparam int unsigned DW = 64;

   logic           ACLK;
   logic           ARESET;
   logic [DW-1:0]  S_TDATA;
   logic           S_TVALID;
   logic           S_TREADY;
   logic           S_TLAST;
   logic [1:0]     S_TUSER;
   logic [1599:0]  Block;
   logic           Block_valid;
   logic           Block_last;
   logic [1:0]     Block_mode;
   logic           Core_ready;

   sha_pad_absorb #(.DATA_WIDTH(DW)) dut (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .S_TDATA     (S_TDATA),
      .S_TVALID    (S_TVALID),
      .S_TREADY    (S_TREADY),
      .S_TLAST     (S_TLAST),
      .S_TUSER     (S_TUSER),
      .Block       (Block),
      .Block_valid (Block_valid),
      .Block_last  (Block_last),
      .Block_mode  (Block_mode),
      .Core_ready  (Core_ready)
   );

   typedef struct {
      logic [1599:0] blk;
      logic          last;
      logic [1:0]    mode;
   } exp_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            rdy_mode = 0;
   int            hs_cyc[$];
   exp_t          exp_q[$];
   logic [63:0]   msg[$];
   logic [1599:0] last_blk;
   logic [1599:0] first_blk;
   logic [1599:0] snap;
   bit            in_blk = 0;
   exp_t          e;
   int            g;

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cmp_blk(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
      int lane  = 0;
      bit found = 0;
      for (int i = 0; i < 25; i++) begin
         if (!found && got[64*i +: 64] !== exp[64*i +: 64]) begin
            lane  = i;
            found = 1;
         end
      end
      check($sformatf("%s_lane%0d", tag, lane), got[64*lane +: 64], exp[64*lane +: 64]);
   endtask

   function automatic int rate_of(input logic [1:0] m);
      case (m)
         2'd0:    return 1152;
         2'd1:    return 1088;
         2'd2:    return 832;
         default: return 576;
      endcase
   endfunction

   // Reference: message bytes ++ 0x06 ++ zeros, last rate byte |= 0x80, split into rate blocks.
   function automatic void push_expected(input logic [1:0] mode);
      logic [7:0] bytes[$];
      logic [63:0] w;
      int rb;
      int nb;
      exp_t x;
      rb = rate_of(mode) / 8;
      foreach (msg[i]) begin
         w = msg[i];
         for (int b = 0; b < 8; b++) begin
`ifdef SHA_PAD_BYTE_SWAP_EN
            bytes.push_back(w[8*(7-b) +: 8]);
`else
            bytes.push_back(w[8*b +: 8]);
`endif
         end
      end
      bytes.push_back(8'h06);
      while (bytes.size() % rb != 0) bytes.push_back(8'h00);
      bytes[bytes.size()-1] = bytes[bytes.size()-1] | 8'h80;
      nb = bytes.size() / rb;
      for (int k = 0; k < nb; k++) begin
         x.blk = '0;
         for (int j = 0; j < rb; j++) x.blk[8*j +: 8] = bytes[k*rb + j];
         x.last = (k == nb - 1);
         x.mode = mode;
         exp_q.push_back(x);
      end
   endfunction

   task automatic drive_word(input logic [63:0] d, input logic last, input logic [1:0] user);
      int guard = 0;
      S_TDATA  = d;
      S_TLAST  = last;
      S_TUSER  = user;
      S_TVALID = 1'b1;
      forever begin
         @(negedge ACLK);
         if (S_TREADY) break;
         guard++;
         if (guard > 5000) begin
            check("tready_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge ACLK);
      #1;
      S_TVALID = 1'b0;
      S_TLAST  = 1'b0;
   endtask

   task automatic send_msg(input logic [1:0] mode, input logic [1:0] later, input bit gaps);
      push_expected(mode);
      for (int i = 0; i < msg.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge ACLK);
            #1;
         end
         drive_word(msg[i], (i == msg.size() - 1), (i == 0) ? mode : later);
      end
   endtask

   task automatic fill_msg(input int n);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back({$urandom, $urandom});
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(negedge ACLK);
         t++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (3) @(posedge ACLK);
      #1;
   endtask

   always @(posedge ACLK) begin
      #1;
      case (rdy_mode)
         0:       Core_ready = 1'b1;
         1:       Core_ready = ($urandom_range(0, 2) != 0);
         default: Core_ready = 1'b0;
      endcase
   end

   // Block consumer: every handshake is scored against the head of the expected queue.
   initial begin
      forever begin
         @(negedge ACLK);
         cyc++;
         if (ARESET) begin
            in_blk = 0;
         end else if (Block_valid) begin
            if (!in_blk) begin
               in_blk    = 1;
               first_blk = Block;
            end
            if (Core_ready) begin
               in_blk   = 0;
               last_blk = Block;
               hs_cyc.push_back(cyc);
               cmp_blk("hold_stable", Block, first_blk);
               check("tready_in_hold", 64'(S_TREADY), 64'd0);
               if (exp_q.size() == 0) begin
                  check("unexpected_block", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  cmp_blk("block", Block, e.blk);
                  check("block_last", 64'(Block_last), 64'(e.last));
                  check("block_mode", 64'(Block_mode), 64'(e.mode));
               end
            end
         end
      end
   end

   initial begin
      Core_ready = 1'b0;
      S_TDATA    = '0;
      S_TVALID   = 1'b0;
      S_TLAST    = 1'b0;
      S_TUSER    = 2'd0;
      ARESET     = 1'b1;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_tready", 64'(S_TREADY), 64'd0);
      check("rst_valid", 64'(Block_valid), 64'd0);
      check("rst_last", 64'(Block_last), 64'd0);
      check("rst_mode", 64'(Block_mode), 64'd0);
      check("rst_block_zero", 64'(|Block), 64'd0);
      ARESET = 1'b0;
      @(posedge ACLK);
      #1;
      check("tready_after_reset", 64'(S_TREADY), 64'd1);

      // single short word, mode 1
      rdy_mode = 0;
      msg.delete();
      msg.push_back(64'h61);
      hs_cyc.delete();
      send_msg(2'd1, 2'd1, 1'b0);
      drain();
      check("one_word_nblk", 64'(hs_cyc.size()), 64'd1);
`ifdef SHA_PAD_BYTE_SWAP_EN
      check("one_word_lane0", last_blk[63:0], 64'h6100000000000000);
`else
      check("one_word_lane0", last_blk[63:0], 64'h61);
`endif
      check("one_word_dom", 64'(last_blk[71:64]), 64'h06);
      check("one_word_tail", 64'(last_blk[1087:1080]), 64'h80);
      check("one_word_ones", 64'($countones(last_blk)), 64'd6);

      // exact rate multiple: full block then padding-only block
      fill_msg(17);
      hs_cyc.delete();
      send_msg(2'd1, 2'd1, 1'b0);
      drain();
      check("exact_nblk", 64'(hs_cyc.size()), 64'd2);
      check("padblk_byte0", 64'(last_blk[7:0]), 64'h06);
      check("padblk_byte135", 64'(last_blk[1087:1080]), 64'h80);
      check("padblk_ones", 64'($countones(last_blk)), 64'd3);

      // core stalled: input must stop and the held block must not move
      rdy_mode = 2;
      fill_msg(20);
      hs_cyc.delete();
      fork
         send_msg(2'd3, 2'd3, 1'b0);
         begin
            g = 0;
            while (!Block_valid && g < 500) begin
               @(negedge ACLK);
               g++;
            end
            check("stall_valid", 64'(Block_valid), 64'd1);
            snap = Block;
            repeat (10) begin
               @(negedge ACLK);
               check("stall_tready", 64'(S_TREADY), 64'd0);
               cmp_blk("stall_stable", Block, snap);
            end
            rdy_mode = 0;
         end
      join
      drain();
      check("stall_nblk", 64'(hs_cyc.size()), 64'd3);

      // full-rate throughput: one block every W+1 cycles
      fill_msg(18);
      hs_cyc.delete();
      send_msg(2'd3, 2'd3, 1'b0);
      drain();
      check("thru_nblk", 64'(hs_cyc.size()), 64'd3);
      check("thru_period", (hs_cyc.size() >= 2) ? 64'(hs_cyc[1] - hs_cyc[0]) : 64'd0, 64'd10);

      // mode change after first word ignored
      fill_msg(20);
      hs_cyc.delete();
      send_msg(2'd1, 2'd3, 1'b1);
      drain();
      check("mode_lock_nblk", 64'(hs_cyc.size()), 64'd2);

      // reset mid-message discards the partial block
      for (int i = 0; i < 5; i++) drive_word({$urandom, $urandom}, 1'b0, 2'd1);
      ARESET = 1'b1;
      #1;
      check("midrst_tready", 64'(S_TREADY), 64'd0);
      check("midrst_mode", 64'(Block_mode), 64'd0);
      check("midrst_block_zero", 64'(|Block), 64'd0);
      check("midrst_valid", 64'(Block_valid), 64'd0);
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      @(posedge ACLK);
      #1;
      check("midrst_tready_after", 64'(S_TREADY), 64'd1);
      fill_msg(1);
      hs_cyc.delete();
      send_msg(2'd2, 2'd2, 1'b0);
      drain();
      check("midrst_nblk", 64'(hs_cyc.size()), 64'd1);

`ifdef SHA_PAD_BYTE_SWAP_EN
      msg.delete();
      msg.push_back(64'h0102030405060708);
      send_msg(2'd1, 2'd1, 1'b0);
      drain();
      check("swap_lane0", last_blk[63:0], 64'h0807060504030201);
`endif

      // randomized messages with random gaps and random core backpressure
      rdy_mode = 1;
      repeat (25) begin
         fill_msg($urandom_range(1, 40));
         send_msg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
